// File: rtl/sha3_pad_buffer.sv
// SHA3-512 rate-block assembler: packs 32-bit message words into 576-bit blocks,
// applies 0x06..0x80 domain padding and hands blocks to absorb over valid/ready.
module sha3_pad_buffer #(
  parameter int BITS = 32,
  parameter int RATE = 576
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_data,
  input  logic            in_last,
  input  logic [2:0]      in_bytes,
  output logic            blk_valid,
  input  logic            blk_ready,
  output logic [RATE-1:0] blk_data,
  output logic            blk_last
);

  localparam int WORDS  = RATE / BITS;
  localparam int RBYTES = RATE / 8;
  localparam int WBYTES = BITS / 8;
  localparam logic [RATE-1:0] PAD_BLK = (RATE'(8'h80) << (RATE - 8)) | RATE'(8'h06);

  typedef enum logic {FILL, OUT} state_t;

  state_t          state;
  logic [4:0]      wcnt;
  logic [RATE-1:0] buffer;
  logic            pend_pad;

  logic [2:0]      nb;
  logic [BITS-1:0] word;
  logic [6:0]      b;
  logic [RATE-1:0] nxt;

  assign in_ready  = (state == FILL) && rst_n;
  assign blk_valid = (state == OUT);
  assign blk_data  = buffer;

  // Next buffer image for an accepted word; buffer bytes past the write point are
  // already zero, so padding only needs to OR in the two marker bytes.
  always_comb begin
    nb   = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    word = in_data;
    if (in_last) begin
      for (int unsigned i = 0; i < WBYTES; i++) begin
        if (!(3'(i) < nb)) word[8*i +: 8] = '0;
      end
    end
    b   = {wcnt, 2'b00} + {4'b0000, nb};
    nxt = buffer;
    for (int unsigned k = 0; k < WORDS; k++) begin
      if (5'(k) == wcnt) nxt[k*BITS +: BITS] = word;
    end
    if (in_last && (b < 7'(RBYTES))) begin
      for (int unsigned j = 0; j < RBYTES; j++) begin
        if (7'(j) == b) nxt[8*j +: 8] = nxt[8*j +: 8] | 8'h06;
      end
      nxt[RATE-1 -: 8] = nxt[RATE-1 -: 8] | 8'h80;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL;
      wcnt     <= '0;
      buffer   <= '0;
      pend_pad <= 1'b0;
      blk_last <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            buffer <= nxt;
            if (!in_last) begin
              if (wcnt == 5'(WORDS - 1)) begin
                wcnt     <= '0;
                blk_last <= 1'b0;
                state    <= OUT;
              end else begin
                wcnt <= wcnt + 5'd1;
              end
            end else begin
              wcnt  <= '0;
              state <= OUT;
              if (b < 7'(RBYTES)) begin
                blk_last <= 1'b1;
              end else begin
                blk_last <= 1'b0;
                pend_pad <= 1'b1;
              end
            end
          end
        end
        OUT: begin
          if (blk_ready) begin
            if (pend_pad) begin
              buffer   <= PAD_BLK;
              blk_last <= 1'b1;
              pend_pad <= 1'b0;
            end else begin
              buffer   <= '0;
              blk_last <= 1'b0;
              state    <= FILL;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_pad_buffer.sv
// Directed bench for sha3_pad_buffer: padding boundaries, pad-only block, backpressure, reset.
module tb_sha3_pad_buffer;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [575:0] blk_data;
  logic         blk_last;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]   msg [72];
  logic [575:0] exp_blk;
  logic [575:0] held;

  localparam logic [575:0] PAD_ONLY = {8'h80, 560'h0, 8'h06};

  sha3_pad_buffer #(.BITS(32), .RATE(576)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives one word and returns #1 after the edge that accepted it.
  task automatic send(input logic [31:0] d, input logic last, input logic [2:0] nbytes);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last; in_bytes = nbytes;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("in_ready_timeout", 576'(in_ready), 576'(1));
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic wait_blk();
    int n = 0;
    while (!blk_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!blk_valid) chk("blk_valid_timeout", 576'(blk_valid), 576'(1));
  endtask

  task automatic handshake();
    blk_ready = 1'b1;
    @(posedge clk); #1;
    blk_ready = 1'b0;
  endtask

  // Sends msg[0..len-1]; unused bytes of the final word carry 0xAB garbage.
  task automatic send_msg(input int len);
    int nw = (len == 0) ? 1 : (len + 3) / 4;
    for (int k = 0; k < nw; k++) begin
      logic [31:0] w;
      int rem = len - 4 * k;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = (i < rem) ? msg[4*k + i] : 8'hAB;
      send(w, k == nw - 1, (k == nw - 1) ? 3'(rem) : 3'd4);
    end
  endtask

  function automatic logic [575:0] model(input int len);
    logic [575:0] r = '0;
    for (int i = 0; i < len; i++) r[8*i +: 8] = msg[i];
    if (len < 72) begin
      r[8*len +: 8] = r[8*len +: 8] | 8'h06;
      r[575:568]    = r[575:568] | 8'h80;
    end
    return r;
  endfunction

  initial begin
    for (int i = 0; i < 72; i++) msg[i] = 8'(i + 1);
    in_valid = 0; in_data = '0; in_last = 0; in_bytes = '0; blk_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 576'(in_ready), 576'(0));
    chk("rst_blk_valid", 576'(blk_valid), 576'(0));
    chk("rst_blk_last", 576'(blk_last), 576'(0));
    chk("rst_blk_data", blk_data, '0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 576'(in_ready), 576'(1));

    // Empty message: all input bytes masked away
    send(32'hDEADBEEF, 1'b1, 3'd0);
    chk("empty_valid", 576'(blk_valid), 576'(1));
    chk("empty_data", blk_data, PAD_ONLY);
    chk("empty_last", 576'(blk_last), 576'(1));
    handshake();
    chk("empty_back_fill", 576'(in_ready), 576'(1));
    chk("empty_valid_drop", 576'(blk_valid), 576'(0));

    // "abc": valid one cycle after accept
    chk("abc_pre_valid", 576'(blk_valid), 576'(0));
    send(32'h00636261, 1'b1, 3'd3);
    chk("abc_valid", 576'(blk_valid), 576'(1));
    chk("abc_word0", 576'(blk_data[31:0]), 576'(32'h06636261));
    chk("abc_word17", 576'(blk_data[575:544]), 576'(32'h80000000));
    chk("abc_data", blk_data, {32'h80000000, 512'h0, 32'h06636261});
    chk("abc_last", 576'(blk_last), 576'(1));
    handshake();

    // in_bytes > 4 clamps to 4
    send(32'h44332211, 1'b1, 3'd7);
    chk("clamp_data", blk_data, {8'h80, 528'h0, 8'h06, 32'h44332211});
    handshake();

    // 71 bytes: pad markers collide in byte 71
    send_msg(71);
    wait_blk();
    chk("m71_word17", 576'(blk_data[575:544]), 576'(32'h86474645));
    chk("m71_data", blk_data, model(71));
    chk("m71_last", 576'(blk_last), 576'(1));
    handshake();
    chk("m71_single", 576'(blk_valid), 576'(0));

    // 72 bytes: data block then pad-only block
    send_msg(72);
    wait_blk();
    chk("m72_blk1", blk_data, model(72));
    chk("m72_blk1_last", 576'(blk_last), 576'(0));
    handshake();
    chk("m72_blk2_valid", 576'(blk_valid), 576'(1));
    chk("m72_blk2_data", blk_data, PAD_ONLY);
    chk("m72_blk2_last", 576'(blk_last), 576'(1));
    chk("m72_blk2_in_ready", 576'(in_ready), 576'(0));
    handshake();
    chk("m72_in_ready", 576'(in_ready), 576'(1));

    // Backpressure: full non-final block, next word held on the input for 10 cycles
    for (int k = 0; k < 18; k++)
      send({msg[4*k+3], msg[4*k+2], msg[4*k+1], msg[4*k]}, 1'b0, 3'd4);
    chk("bp_valid", 576'(blk_valid), 576'(1));
    held = blk_data;
    chk("bp_blk1", held, model(72));
    in_valid = 1'b1; in_data = 32'hCAFEF00D; in_last = 1'b0; in_bytes = 3'd4;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("bp_stable_data", blk_data, held);
      chk("bp_stable_last", 576'(blk_last), 576'(0));
      chk("bp_in_ready", 576'(in_ready), 576'(0));
    end
    handshake();
    send(32'hCAFEF00D, 1'b0, 3'd4);
    send(32'h00BB7766, 1'b1, 3'd2);
    chk("bp_blk2", blk_data, {8'h80, 504'h0, 32'h00067766, 32'hCAFEF00D});
    chk("bp_blk2_last", 576'(blk_last), 576'(1));
    handshake();

    // Reset mid-fill discards the partial block
    for (int k = 0; k < 5; k++) send(32'h11111111 * (k + 1), 1'b0, 3'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_blk_valid", 576'(blk_valid), 576'(0));
    chk("mid_rst_in_ready", 576'(in_ready), 576'(0));
    chk("mid_rst_data", blk_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(32'h00636261, 1'b1, 3'd3);
    chk("rst_abc_data", blk_data, {32'h80000000, 512'h0, 32'h06636261});
    chk("rst_abc_last", 576'(blk_last), 576'(1));
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sha3_pad_buffer.md
Name: sha3_pad_buffer

Overview:
- Upstream feeder for the SHA3-512 absorb stage (rate r = 576 bits = 72 bytes = 18 words).
- Collects 32-bit message words from the bus-side controller and applies SHA3 domain padding (0x06 ... 0x80).
- Presents complete 576-bit rate blocks to absorb over a valid/ready handshake.
- Emits an extra pad-only block when the message ends exactly on a block boundary.

Parameters:
BITS, 32, input word width (fixed; only 32 supported)
RATE, 576, block width in bits; WORDS = RATE/BITS = 18, RBYTES = RATE/8 = 72

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  message word valid
in_ready  output  1  block accepts a word this cycle
in_data  input  BITS  message word; byte 0 = bits [7:0]
in_last  input  1  word is the final word of the message
in_bytes  input  3  valid bytes in final word, 0..4; ignored when in_last=0; values >4 treated as 4
blk_valid  output  1  blk_data holds a complete padded or full block
blk_ready  input  1  absorb stage consumes the block
blk_data  output  RATE  block; word k = bits [32k+31:32k]; byte j = bits [8j+7:8j]
blk_last  output  1  block is the final (padded) block of the message

Behaviour:
- Reset (async assert, sync deassert by clk): state=FILL, wcnt=0, buffer=0, pend_pad=0, blk_valid=0, blk_last=0, blk_data=0; in_ready=0 while rst_n=0.
- in_ready = (state==FILL). blk_valid = (state==OUT). No combinational path from blk_ready to in_ready.
- Word accept = in_valid & in_ready; block handshake = blk_valid & blk_ready.
- FILL, accept with in_last=0: buffer word[wcnt] <= in_data; if wcnt==17 then wcnt<=0, blk_last<=0, state<=OUT; else wcnt++.
- FILL, accept with in_last=1: nb = min(in_bytes,4); bytes of in_data at index >= nb are masked to 0; b = 4*wcnt + nb.
  - b < 72: byte[b] |= 0x06; byte[71] |= 0x80 (b==71 gives 0x86); all bytes beyond b stay 0; blk_last<=1; state<=OUT.
  - b == 72 (wcnt==17, nb==4): blk_last<=0; pend_pad<=1; state<=OUT.
  - wcnt<=0 in both cases.
- in_last=1 with in_bytes=0 at wcnt=0 is the empty message: block = 0x06 at byte 0, 0x80 at byte 71, blk_last=1.
- OUT: blk_data and blk_last held stable until handshake; in_valid ignored (in_ready=0).
  - Handshake with pend_pad=1: buffer <= pad-only block (byte0=0x06, byte71=0x80); blk_last<=1; pend_pad<=0; stay OUT (blk_valid stays 1).
  - Handshake with pend_pad=0: buffer<=0; blk_last<=0; state<=FILL.
- Latency: blk_valid rises the cycle after the accepting edge of the 18th word or the last word.
- Throughput: one dead cycle per block (the OUT->FILL return); 19 cycles per full block minimum.
- Buffer must be zero at the start of every block; stale bytes from a previous message never appear.
- Reset mid-operation (any state): partial block and pending pad discarded; outputs return to reset values immediately.
- blk_data = buffer register directly (no combinational padding on the output).

Test Plan:
- Empty message: in_last=1, in_bytes=0 at reset state -> one block, byte0=0x06, byte71=0x80, all other bytes 0x00, blk_last=1.
- "abc": in_data=0x00636261, in_bytes=3, in_last=1 -> word0=0x06636261, word17=0x80000000, blk_last=1, blk_valid rises 1 cycle after accept.
- 71-byte message (17 full words + in_bytes=3) -> byte71=0x86, bytes 0..70 match input, single block, blk_last=1.
- 72-byte message (18 full words, last with in_bytes=4) -> block1 = data with blk_last=0; after handshake, block2 = 0x06 at byte0, 0x80 at byte71, blk_last=1; then in_ready=1.
- Backpressure: blk_ready=0 for 10 cycles while in_valid=1 -> blk_data/blk_last stable, in_ready=0, no words lost; the next message starts cleanly from a zeroed buffer.
- Reset mid-fill: 5 words accepted, rst_n pulsed low -> blk_valid=0, in_ready=0 during reset; a following "abc" message yields exactly the "abc" block above.
